ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter AW, default 10, meaning the instruction RAM word-address width.
REQ-003 SHALL have port clka  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port iram_ena  out  1  instruction RAM read enable.
REQ-006 SHALL have port iram_addra  out  AW  instruction RAM word address, equal to pc[AW+1:2].
REQ-007 SHALL have port iram_douta  in  32  instruction RAM read data, valid one cycle after an enabled read.
REQ-008 SHALL have port id_ready  in  1  decode stage accepts if_instr and if_pc this cycle.
REQ-009 SHALL have port redirect  in  1  branch or jump redirect request from downstream.
REQ-010 SHALL have port redirect_pc  in  32  byte target address for a redirect.
REQ-011 SHALL have port if_valid  out  1  if_instr and if_pc hold a valid fetched instruction.
REQ-012 SHALL have port if_instr  out  32  fetched instruction, registered.
REQ-013 SHALL have port if_pc  out  32  byte address of if_instr, registered.

Function
REQ-014 SHALL hold a 32-bit fetch PC register; iram_addra SHALL be driven combinationally from it.
REQ-015 SHALL assert iram_ena only when no read is in flight into a full skid buffer, the skid buffer is empty, and no stall is active, i.e. in state RUN.
REQ-016 SHALL advance the PC by 4 on every edge where iram_ena=1 and redirect=0, with 32-bit wrap-around; iram_addra therefore wraps from 2^AW-1 to 0.
REQ-017 SHALL present an instruction read at edge N on if_instr/if_pc with if_valid=1 after edge N+1 (two-edge latency), sustaining one instruction per cycle while id_ready=1.
REQ-018 SHALL hold if_valid, if_instr and if_pc stable while if_valid=1 and id_ready=0.
REQ-019 SHALL capture a read that lands while the output is stalled into a one-entry skid buffer, and SHALL neither lose nor duplicate any instruction.
REQ-020 SHALL implement states RUN (issuing reads), HOLD (output stalled with the skid buffer full, iram_ena=0) and FLUSH (one cycle after a redirect, discarding in-flight data).
REQ-021 SHALL transition RUN->HOLD when id_ready=0 with if_valid=1 and a read is landing, HOLD->RUN when id_ready=1 (skid moves to output), and any state->FLUSH on redirect=1.
REQ-022 On redirect=1 at an edge, SHALL load PC with redirect_pc, clear if_valid, clear the skid buffer and discard the in-flight read; the first redirect-target read SHALL issue in the next cycle.
REQ-023 SHALL give redirect priority over id_ready=0 and over an in-flight or skid-buffered instruction.
REQ-024 Without REQ-030, SHALL force redirect_pc[1:0] to 2'b00.

Reset
REQ-025 While rst_n=0, SHALL set PC=RESET_PC, if_valid=0, if_instr=32'h0, if_pc=32'h0, skid buffer empty and iram_ena=0.
REQ-026 SHALL assert iram_ena with iram_addra=RESET_PC[AW+1:2] in the first cycle after rst_n rises.
REQ-027 A reset asserted mid-stream SHALL discard all in-flight and buffered instructions immediately.

Configuration
REQ-028 SHALL recognise macro IFETCH_MISALIGN_TRAP_EN.
REQ-029 Without the macro, SHALL have no extra port and SHALL apply REQ-024.
REQ-030 With the macro, SHALL add output if_misalign (1 bit, reset 0); a redirect with redirect_pc[1:0]!=0 SHALL set if_misalign=1, hold if_valid=0 and iram_ena=0 until an aligned redirect or reset clears it.

Verification
REQ-031 RAM word k = k, reset release, id_ready=1 -> if_pc 0,4,8,... with if_instr 0,1,2,...; if_valid rises after the second edge following release.
REQ-032 Streaming with id_ready=0 for 3 cycles -> contiguous if_pc sequence with no gaps or repeats; iram_ena=0 while in HOLD.
REQ-033 Redirect to 0x40 mid-stream -> next valid if_pc=0x40 with if_instr=16; no stale if_valid in between.
REQ-034 Redirect to 0x80 in the same cycle as id_ready=0 and a full skid buffer -> redirect wins; next valid if_pc=0x80.
REQ-035 Redirect to 0xFFC -> iram_addra 0x3FF then 0x000; if_pc 0xFFC then 0x1000.
REQ-036 With IFETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> if_misalign=1, if_valid=0, iram_ena=0; redirect to 0x44 -> if_misalign=0 and fetch resumes at 0x44.

Source files
------------

// File: rtl/ifetch_unit.sv
// Single-issue instruction fetch: PC register, registered output stage and a one-entry skid buffer.
// Optional misaligned-redirect trap is enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 10
) (
  input  logic          clka,
  input  logic          rst_n,
  output logic          iram_ena,
  output logic [AW-1:0] iram_addra,
  input  logic [31:0]   iram_douta,
  input  logic          id_ready,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic          if_misalign
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, tgt, inflight_pc;
  logic        inflight, skid_vld, landing, stall, trap;
  fetch_t      skid_q, land;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign tgt         = redirect_pc;
  assign trap        = misalign_q;
  assign if_misalign = misalign_q;

  // Trap sticks until the next redirect; an aligned redirect clears it.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)        misalign_q <= 1'b0;
    else if (redirect) misalign_q <= |redirect_pc[1:0];
  end
`else
  assign tgt  = redirect_pc & 32'hFFFF_FFFC;
  assign trap = 1'b0;
`endif

  assign iram_addra = pc_q[AW+1:2];
  assign landing    = inflight && (state_q != FLUSH);
  assign stall      = if_valid && !id_ready;
  assign land       = {inflight_pc, iram_douta};

  // Never issue a read whose data could arrive while the skid entry is occupied.
  assign iram_ena = rst_n && (state_q != HOLD) && !skid_vld && !(landing && stall) && !trap;

  always_comb begin
    state_d = state_q;
    if (redirect) state_d = FLUSH;
    else begin
      case (state_q)
        RUN, FLUSH: state_d = (landing && stall) ? HOLD : RUN;
        HOLD:       if (id_ready) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      skid_vld    <= 1'b0;
      skid_q      <= '0;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_q     <= tgt;
        inflight <= 1'b0;
        skid_vld <= 1'b0;
        if_valid <= 1'b0;
      end else begin
        inflight <= iram_ena;
        if (iram_ena) begin
          pc_q        <= pc_q + 32'd4;
          inflight_pc <= pc_q;
        end
        if (skid_vld) begin
          if (id_ready) begin
            if_pc    <= skid_q.pc;
            if_instr <= skid_q.instr;
            skid_vld <= 1'b0;
          end
        end else if (landing) begin
          if (stall) begin
            skid_q   <= land;
            skid_vld <= 1'b1;
          end else begin
            if_pc    <= land.pc;
            if_instr <= land.instr;
            if_valid <= 1'b1;
          end
        end else if (!stall) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule
